ssd1306_spi_decoder: RTL and testbench

- Upstream stage of the SSD1306-to-VGA framebuffer. Oversamples the host's 4-wire SPI (SCLK, MOSI, CS#, D/C#) in the 25 MHz pixel-clock domain.
- Decodes the SSD1306 command subset that affects GDDRAM addressing and display state.
- Emits byte-wide framebuffer writes at the address the panel itself would use, so the VGA renderer shows exactly what the panel would.

---
 rtl/ssd1306_pkg.sv | 37 +++
 rtl/spi_byte_rx.sv | 78 +++++++
 rtl/ssd1306_spi_decoder.sv | 167 ++++++++++++++++
 tb/tb_ssd1306_spi_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd1306_pkg.sv
// Shared types, opcodes and geometry for the SSD1306 SPI front end.
package ssd1306_pkg;

  localparam int unsigned NUM_COLS  = 128;
  localparam int unsigned NUM_PAGES = 8;
  localparam int unsigned COL_W     = $clog2(NUM_COLS);
  localparam int unsigned PAGE_W    = $clog2(NUM_PAGES);

  typedef enum logic [1:0] {
    MODE_HORIZ = 2'd0,
    MODE_VERT  = 2'd1,
    MODE_PAGE  = 2'd2
  } mode_e;

  typedef enum logic {
    ST_CMD = 1'b0,
    ST_ARG = 1'b1
  } state_e;

  localparam logic [7:0] OP_SET_MODE  = 8'h20;
  localparam logic [7:0] OP_COL_ADDR  = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
  localparam logic [7:0] OP_CONTRAST  = 8'h81;

  // Number of argument bytes following an opcode; 0 for single-byte commands.
  function automatic logic [2:0] cmd_arg_count(input logic [7:0] op);
    case (op)
      8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
      8'hD5, 8'hD9, 8'hDA, 8'hDB:          cmd_arg_count = 3'd1;
      8'h21, 8'h22, 8'hA3:                 cmd_arg_count = 3'd2;
      8'h29, 8'h2A:                        cmd_arg_count = 3'd5;
      8'h26, 8'h27:                        cmd_arg_count = 3'd6;
      default:                             cmd_arg_count = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronisers, SCLK rise detect, MSB-first
// shift register, chip-select abort.
module spi_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       greset_i,
  input  logic       sclk_i,
  input  logic       mosi_i,
  input  logic       cs_n_i,
  input  logic       dc_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       dc_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_n_sync_q;
  logic [SYNC_STAGES-1:0] dc_sync_q;
  logic                   sclk_prev_q;
  logic [2:0]             bit_cnt_q;
  logic [6:0]             shift_q;
  logic                   valid_q;
  logic [7:0]             byte_q;
  logic                   dc_q;

  logic sclk_s;
  logic mosi_s;
  logic cs_n_s;
  logic dc_s;
  logic sclk_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign dc_s      = dc_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk_i) begin
    if (!greset_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_n_sync_q <= '1;
      dc_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      valid_q     <= 1'b0;
      byte_q      <= 8'd0;
      dc_q        <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n_i};
      dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
      sclk_prev_q <= sclk_s;
      valid_q     <= 1'b0;
      // Deselect drops any partial byte; the counter wraps 7->0 on completion.
      if (cs_n_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          valid_q <= 1'b1;
          byte_q  <= {shift_q, mosi_s};
          dc_q    <= dc_s;
        end
      end
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign dc_o         = dc_q;

endmodule

// File: rtl/ssd1306_spi_decoder.sv
// SSD1306 command decoder and GDDRAM address generator feeding the framebuffer.
//   state  | meaning
//   ST_CMD | next command byte is an opcode
//   ST_ARG | next command byte is an argument of opcode_q (args_left_q remain)
module ssd1306_spi_decoder
  import ssd1306_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FB_ADDR_W   = 10
) (
  input  logic                 clk_i,
  input  logic                 greset_i,
  input  logic                 spi_sclk_i,
  input  logic                 spi_mosi_i,
  input  logic                 spi_cs_n_i,
  input  logic                 spi_dc_i,
  output logic                 fb_we_o,
  output logic [FB_ADDR_W-1:0] fb_addr_o,
  output logic [7:0]           fb_wdata_o,
  output logic                 display_on_o,
  output logic                 display_invert_o,
  output logic [7:0]           contrast_o
);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_dc;

  spi_byte_rx #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx (
    .clk_i       (clk_i),
    .greset_i    (greset_i),
    .sclk_i      (spi_sclk_i),
    .mosi_i      (spi_mosi_i),
    .cs_n_i      (spi_cs_n_i),
    .dc_i        (spi_dc_i),
    .byte_valid_o(rx_valid),
    .byte_o      (rx_byte),
    .dc_o        (rx_dc)
  );

  state_e              state_q;
  mode_e               mode_q;
  logic [7:0]          opcode_q;
  logic [2:0]          args_left_q;
  logic [COL_W-1:0]    col_q, col_start_q, col_end_q;
  logic [PAGE_W-1:0]   page_q, page_start_q, page_end_q;
  logic                fb_we_q;
  logic [FB_ADDR_W-1:0] fb_addr_q;
  logic [7:0]          fb_wdata_q;
  logic                display_on_q;
  logic                display_invert_q;
  logic [7:0]          contrast_q;

  logic [COL_W-1:0]  col_d;
  logic [PAGE_W-1:0] page_d;
  logic [2:0]        arg_cnt;

  assign arg_cnt = cmd_arg_count(rx_byte);

  // Pointer after a data write. Plain increments wrap 127->0 / 7->0 by width,
  // which covers windows whose start lies beyond their end.
  always_comb begin
    col_d  = col_q + 1'b1;
    page_d = page_q;
    case (mode_q)
      MODE_HORIZ: begin
        if (col_q == col_end_q) begin
          col_d  = col_start_q;
          page_d = (page_q == page_end_q) ? page_start_q : page_q + 1'b1;
        end
      end
      MODE_VERT: begin
        col_d = col_q;
        if (page_q == page_end_q) begin
          page_d = page_start_q;
          col_d  = (col_q == col_end_q) ? col_start_q : col_q + 1'b1;
        end else begin
          page_d = page_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!greset_i) begin
      state_q          <= ST_CMD;
      mode_q           <= MODE_PAGE;
      opcode_q         <= 8'd0;
      args_left_q      <= 3'd0;
      col_q            <= '0;
      col_start_q      <= '0;
      col_end_q        <= COL_W'(NUM_COLS - 1);
      page_q           <= '0;
      page_start_q     <= '0;
      page_end_q       <= PAGE_W'(NUM_PAGES - 1);
      fb_we_q          <= 1'b0;
      fb_addr_q        <= '0;
      fb_wdata_q       <= 8'd0;
      display_on_q     <= 1'b0;
      display_invert_q <= 1'b0;
      contrast_q       <= 8'h7F;
    end else begin
      fb_we_q <= 1'b0;
      if (rx_valid) begin
        if (rx_dc) begin
          fb_we_q    <= 1'b1;
          fb_addr_q  <= FB_ADDR_W'({page_q, col_q});
          fb_wdata_q <= rx_byte;
          col_q      <= col_d;
          page_q     <= page_d;
        end else if (state_q == ST_CMD) begin
          if (rx_byte[7:4] == 4'h0) begin
            col_q[3:0] <= rx_byte[3:0];
          end else if (rx_byte[7:4] == 4'h1) begin
            col_q[6:4] <= rx_byte[2:0];
          end else if (rx_byte[7:3] == 5'b10110) begin
            page_q <= rx_byte[2:0];
          end else if (rx_byte[7:1] == 7'b1010111) begin
            display_on_q <= rx_byte[0];
          end else if (rx_byte[7:1] == 7'b1010011) begin
            display_invert_q <= rx_byte[0];
          end else if (arg_cnt != 3'd0) begin
            opcode_q    <= rx_byte;
            args_left_q <= arg_cnt;
            state_q     <= ST_ARG;
          end
        end else begin
          args_left_q <= args_left_q - 3'd1;
          if (args_left_q == 3'd1) state_q <= ST_CMD;
          // Two-argument window commands: args_left_q==2 marks the first argument.
          case (opcode_q)
            OP_SET_MODE:  mode_q <= (rx_byte[1:0] == 2'd3) ? MODE_PAGE : mode_e'(rx_byte[1:0]);
            OP_CONTRAST:  contrast_q <= rx_byte;
            OP_COL_ADDR: begin
              if (args_left_q == 3'd2) begin
                col_start_q <= rx_byte[6:0];
                col_q       <= rx_byte[6:0];
              end else begin
                col_end_q   <= rx_byte[6:0];
              end
            end
            OP_PAGE_ADDR: begin
              if (args_left_q == 3'd2) begin
                page_start_q <= rx_byte[2:0];
                page_q       <= rx_byte[2:0];
              end else begin
                page_end_q   <= rx_byte[2:0];
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign fb_we_o          = fb_we_q;
  assign fb_addr_o        = fb_addr_q;
  assign fb_wdata_o       = fb_wdata_q;
  assign display_on_o     = display_on_q;
  assign display_invert_o = display_invert_q;
  assign contrast_o       = contrast_q;

endmodule

// File: tb/tb_ssd1306_spi_decoder.sv
// Self-checking bench: directed scenarios plus randomized command/data stream
// compared against a byte-level model of the panel's addressing rules.
module tb_ssd1306_spi_decoder;

  logic       clk = 1'b0;
  logic       greset;
  logic       spi_sclk, spi_mosi, spi_cs_n, spi_dc;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic       display_on, display_invert;
  logic [7:0] contrast;

  always #20 clk = ~clk;

  ssd1306_spi_decoder #(.SYNC_STAGES(2), .FB_ADDR_W(10)) dut (
    .clk_i           (clk),
    .greset_i        (greset),
    .spi_sclk_i      (spi_sclk),
    .spi_mosi_i      (spi_mosi),
    .spi_cs_n_i      (spi_cs_n),
    .spi_dc_i        (spi_dc),
    .fb_we_o         (fb_we),
    .fb_addr_o       (fb_addr),
    .fb_wdata_o      (fb_wdata),
    .display_on_o    (display_on),
    .display_invert_o(display_invert),
    .contrast_o      (contrast)
  );

  int tests = 0;
  int fails = 0;
  int nbytes = 0;

  // Observed writes, captured away from the active edge.
  int wq_addr[$];
  int wq_data[$];
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wq_addr.push_back(int'(fb_addr));
      wq_data.push_back(int'(fb_wdata));
    end
  end

  // Reference model state (plain integers).
  int m_mode, m_col, m_page, m_cs, m_ce, m_ps, m_pe;
  int m_on, m_inv, m_con;
  int m_need, m_op;
  int m_args[$];
  int ex_addr[$];
  int ex_data[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at byte %0d: observed 0x%0h required 0x%0h", tag, nbytes, obs, exp);
    end
  endtask

  function automatic int arg_count(input int op);
    case (op)
      'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
      'h21, 'h22, 'hA3: return 2;
      'h29, 'h2A:       return 5;
      'h26, 'h27:       return 6;
      default:          return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_mode = 2; m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_on = 0; m_inv = 0; m_con = 'h7F; m_need = 0; m_op = 0;
    m_args.delete();
  endtask

  task automatic m_advance();
    if (m_mode == 0) begin
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else m_col = (m_col + 1) % 128;
    end else if (m_mode == 1) begin
      if (m_page == m_pe) begin
        m_page = m_ps;
        m_col = (m_col == m_ce) ? m_cs : (m_col + 1) % 128;
      end else m_page = (m_page + 1) % 8;
    end else begin
      m_col = (m_col + 1) % 128;
    end
  endtask

  // Arguments are collected and applied once the command is complete.
  task automatic m_apply();
    case (m_op)
      'h20: m_mode = m_args[0] % 4;
      'h81: m_con = m_args[0];
      'h21: begin m_cs = m_args[0] % 128; m_col = m_cs; m_ce = m_args[1] % 128; end
      'h22: begin m_ps = m_args[0] % 8; m_page = m_ps; m_pe = m_args[1] % 8; end
      default: ;
    endcase
  endtask

  task automatic m_byte(input int b, input int dc);
    if (dc != 0) begin
      ex_addr.push_back(m_page * 128 + m_col);
      ex_data.push_back(b);
      m_advance();
    end else if (m_need > 0) begin
      m_args.push_back(b);
      m_need--;
      if (m_need == 0) m_apply();
    end else if (b < 'h10) m_col = (m_col / 16) * 16 + b;
    else if (b < 'h20) m_col = (b % 8) * 16 + (m_col % 16);
    else if (b >= 'hB0 && b <= 'hB7) m_page = b - 'hB0;
    else if (b == 'hAE || b == 'hAF) m_on = b - 'hAE;
    else if (b == 'hA6 || b == 'hA7) m_inv = b - 'hA6;
    else if (arg_count(b) > 0) begin
      m_op = b; m_need = arg_count(b); m_args.delete();
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic dc, input int nbits, input int half);
    spi_cs_n = 1'b0;
    spi_dc   = dc;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (half) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic check_out();
    chk("wr_count", wq_addr.size(), ex_addr.size());
    while (wq_addr.size() > 0 && ex_addr.size() > 0) begin
      chk("wr_addr", wq_addr.pop_front(), ex_addr.pop_front());
      chk("wr_data", wq_data.pop_front(), ex_data.pop_front());
    end
    wq_addr.delete(); wq_data.delete(); ex_addr.delete(); ex_data.delete();
    chk("display_on", display_on, m_on);
    chk("display_invert", display_invert, m_inv);
    chk("contrast", contrast, m_con);
  endtask

  task automatic xfer(input int b, input int dc, input int half);
    nbytes++;
    send_bits(8'(b), 1'(dc), 8, half);
    m_byte(b, dc);
    repeat (6) @(negedge clk);
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    greset = 1'b0;
    @(negedge clk);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_addr", fb_addr, 0);
    chk("rst_fb_wdata", fb_wdata, 0);
    chk("rst_display_on", display_on, 0);
    chk("rst_invert", display_invert, 0);
    chk("rst_contrast", contrast, 'h7F);
    greset = 1'b1;
    m_reset();
    @(negedge clk);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int junk [6];
    int k, half, n, a, b;
    greset = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; spi_dc = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();

    // Basic data writes at SCLK = clk/8.
    xfer('hA5, 1, 4);
    chk("first_addr", fb_addr, 0);
    chk("first_data", fb_wdata, 'hA5);
    xfer($urandom_range(0, 255), 1, 4);
    chk("second_addr", fb_addr, 1);

    // Horizontal mode inside a 2x2 window.
    xfer('h20, 0, 3); xfer('h00, 0, 3);
    xfer('h21, 0, 3); xfer('h02, 0, 3); xfer('h03, 0, 3);
    xfer('h22, 0, 3); xfer('h01, 0, 3); xfer('h02, 0, 3);
    xfer($urandom_range(0, 255), 1, 3);
    chk("horiz_first", fb_addr, 130);
    repeat (4) xfer($urandom_range(0, 255), 1, 3);
    chk("horiz_wrap", fb_addr, 130);

    // Page mode with column wrap at 127.
    xfer('h20, 0, 3); xfer('h02, 0, 3);
    xfer('hB3, 0, 3); xfer('h05, 0, 3); xfer('h17, 0, 3);
    xfer($urandom_range(0, 255), 1, 2);
    chk("page_first", fb_addr, 501);
    repeat (127) xfer($urandom_range(0, 255), 1, 2);
    chk("page_last", fb_addr, 500);

    // Aborted fragment, then a full byte.
    do_reset();
    send_bits(8'hC3, 1'b1, 5, 3);
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check_out();
    xfer('h3C, 1, 3);
    chk("abort_addr", fb_addr, 0);
    chk("abort_data", fb_wdata, 'h3C);

    // Display state commands and a consumed scroll setup.
    xfer('hAF, 0, 2);
    chk("disp_on_set", display_on, 1);
    xfer('hA7, 0, 2); xfer('h81, 0, 2); xfer('h40, 0, 2); xfer('h26, 0, 2);
    junk = '{'hAE, 'hA6, 'hB5, 'h05, 'h20, 'h81};
    for (int i = 0; i < 6; i++) xfer(junk[i], 0, 2);
    chk("invert_set", display_invert, 1);
    chk("contrast_set", contrast, 'h40);
    chk("disp_on_kept", display_on, 1);
    xfer('hAE, 0, 2);
    chk("disp_off", display_on, 0);
    xfer($urandom_range(0, 255), 1, 2);
    chk("scroll_no_addr", fb_addr, 1);

    // Reset mid-byte and mid-argument.
    send_bits(8'hFF, 1'b1, 4, 3);
    do_reset();
    xfer('h5A, 1, 3);
    chk("midbyte_addr", fb_addr, 0);
    xfer('h21, 0, 3); xfer('h05, 0, 3);
    do_reset();
    xfer($urandom_range(0, 255), 1, 3);
    chk("midarg_addr", fb_addr, 0);

    // Randomized command/data stream.
    for (int it = 0; it < 60; it++) begin
      k = $urandom_range(0, 9);
      half = $urandom_range(2, 4);
      case (k)
        0, 1, 2: begin
          n = $urandom_range(1, 4);
          repeat (n) xfer($urandom_range(0, 255), 1, half);
        end
        3: begin xfer('h20, 0, half); xfer($urandom_range(0, 255), 0, half); end
        4: begin
          a = $urandom_range(0, 255); b = $urandom_range(0, 255);
          xfer('h21, 0, half); xfer(a, 0, half); xfer(b, 0, half);
        end
        5: begin
          a = $urandom_range(0, 255); b = $urandom_range(0, 255);
          xfer('h22, 0, half); xfer(a, 0, half); xfer(b, 0, half);
        end
        6: xfer($urandom_range(0, 'h1F), 0, half);
        7: xfer('hB0 + $urandom_range(0, 7), 0, half);
        8: begin
          a = $urandom_range(0, 3);
          xfer((a < 2) ? ('hAE + a) : ('hA6 + a - 2), 0, half);
          xfer('h81, 0, half); xfer($urandom_range(0, 255), 0, half);
        end
        default: begin
          send_bits(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(1, 7), half);
          spi_cs_n = 1'b1;
          repeat (6) @(negedge clk);
          check_out();
        end
      endcase
    end

    repeat (10) @(negedge clk);
    chk("tail_writes", wq_addr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
